// File: rtl/contador_cmd_gen.sv
// Command generator for an N-bit up/down counter: button presses become one-cycle
// clear/load/enable strobes with modulo-(LIMIT+1) wrap. Define AUTOREPEAT_EN for hold-to-repeat.
module contador_cmd_gen #(
  parameter int N          = 6,
  parameter int LIMIT      = 59,
  parameter int DELAY_CYC  = 8,
  parameter int PERIOD_CYC = 4
) (
  input  logic         clock_clk_in,
  input  logic         reset_rst_in,
  input  logic         btn_up_in,
  input  logic         btn_down_in,
  input  logic         btn_clr_in,
  input  logic         preset_load_in,
  input  logic [N-1:0] preset_in,
  input  logic [N-1:0] q_in,
  output logic         syn_clr_o,
  output logic         load_o,
  output logic         en_o,
  output logic         up_o,
  output logic [N-1:0] d_o,
  output logic         repeat_o
);

  // Encoding order is the priority order, so a plain compare picks the winner.
  typedef enum logic [2:0] {EV_NONE, EV_DOWN, EV_UP, EV_LOAD, EV_CLR} ev_t;

  localparam logic [N-1:0] C_LIMIT = N'(LIMIT);

  if (LIMIT < 1 || LIMIT > (1 << N) - 1 || DELAY_CYC < 2 || PERIOD_CYC < 2) begin : g_param_chk
    $error("contador_cmd_gen: illegal parameter set");
  end

  logic         r_prev_up, r_prev_dn, r_prev_clr;
  ev_t          r_pend;
  logic [N-1:0] r_pend_d;
  logic         r_syn_clr, r_load, r_en, r_up;
  logic [N-1:0] r_d;

  logic         w_press_up, w_press_dn, w_press_clr, w_both, w_guard;
  ev_t          w_new_ev, w_ev, w_issue;
  logic [N-1:0] w_new_d, w_ev_d;
  logic         w_syn_clr_nx, w_load_nx, w_en_nx, w_up_nx;
  logic [N-1:0] w_d_nx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_press_up  = btn_up_in & ~r_prev_up;
    w_press_dn  = btn_down_in & ~r_prev_dn;
    w_press_clr = btn_clr_in & ~r_prev_clr;
    w_both      = btn_up_in & btn_down_in;
    w_guard     = r_syn_clr | r_load | r_en;
    w_new_d     = (preset_in > C_LIMIT) ? C_LIMIT : preset_in;
    w_new_ev    = EV_NONE;
    if (w_press_clr)                 w_new_ev = EV_CLR;
    else if (preset_load_in)         w_new_ev = EV_LOAD;
    else if (!w_both && w_press_up)  w_new_ev = EV_UP;
    else if (!w_both && w_press_dn)  w_new_ev = EV_DOWN;
    // A held event beats a newer one of equal rank.
    w_ev   = r_pend;
    w_ev_d = r_pend_d;
    if (w_new_ev > r_pend) begin
      w_ev   = w_new_ev;
      w_ev_d = w_new_d;
    end
  end

`ifdef AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_tmr, w_tmr_nx, w_tmr_lim;
  logic        r_dir, w_dir_nx, r_repeat;
  logic        w_held, w_at_lim, w_tick, w_fresh;

  always_comb begin
    w_held    = r_dir ? btn_up_in : btn_down_in;
    w_tmr_lim = (r_state == S_DELAY) ? 16'(DELAY_CYC - 1) : 16'(PERIOD_CYC - 1);
    w_at_lim  = (r_tmr == w_tmr_lim);
    w_tick    = (r_state != S_IDLE) && w_held && !w_both && !w_press_clr && w_at_lim;
    // Repeat ticks are never held over; a blocked tick is simply skipped.
    w_issue = EV_NONE;
    if (!w_guard) begin
      if (w_ev != EV_NONE) w_issue = w_ev;
      else if (w_tick)     w_issue = r_dir ? EV_UP : EV_DOWN;
    end
    w_fresh    = !w_guard && (w_ev == EV_UP || w_ev == EV_DOWN);
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr + 16'd1;
    w_dir_nx   = r_dir;
    if (w_both || w_press_clr) begin
      w_state_nx = S_IDLE;
      w_tmr_nx   = '0;
    end else if (w_fresh) begin
      w_state_nx = S_DELAY;
      w_tmr_nx   = '0;
      w_dir_nx   = (w_ev == EV_UP);
    end else if (r_state == S_IDLE || !w_held) begin
      w_state_nx = S_IDLE;
      w_tmr_nx   = '0;
    end else if (w_at_lim) begin
      w_state_nx = S_REPEAT;
      w_tmr_nx   = '0;
    end
  end

  always_ff @(posedge clock_clk_in or posedge reset_rst_in) begin
    if (reset_rst_in) begin
      r_state  <= S_IDLE;
      r_tmr    <= '0;
      r_dir    <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tmr    <= w_tmr_nx;
      r_dir    <= w_dir_nx;
      r_repeat <= (w_state_nx == S_REPEAT);
    end
  end

  assign repeat_o = r_repeat;
`else
  always_comb w_issue = w_guard ? EV_NONE : w_ev;

  assign repeat_o = 1'b0;
`endif

  // Steps wrap by loading the opposite end instead of counting past it.
  always_comb begin
    w_syn_clr_nx = 1'b0;
    w_load_nx    = 1'b0;
    w_en_nx      = 1'b0;
    w_up_nx      = 1'b0;
    w_d_nx       = '0;
    unique case (w_issue)
      EV_CLR:  w_syn_clr_nx = 1'b1;
      EV_LOAD: begin
        w_load_nx = 1'b1;
        w_d_nx    = w_ev_d;
      end
      EV_UP: begin
        if (q_in >= C_LIMIT) w_load_nx = 1'b1;
        else begin
          w_en_nx = 1'b1;
          w_up_nx = 1'b1;
        end
      end
      EV_DOWN: begin
        if (q_in == '0 || q_in > C_LIMIT) begin
          w_load_nx = 1'b1;
          w_d_nx    = C_LIMIT;
        end else w_en_nx = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock_clk_in or posedge reset_rst_in) begin
    if (reset_rst_in) begin
      r_prev_up  <= 1'b1;
      r_prev_dn  <= 1'b1;
      r_prev_clr <= 1'b1;
      r_pend     <= EV_NONE;
      r_pend_d   <= '0;
      r_syn_clr  <= 1'b0;
      r_load     <= 1'b0;
      r_en       <= 1'b0;
      r_up       <= 1'b0;
      r_d        <= '0;
    end else begin
      r_prev_up  <= btn_up_in;
      r_prev_dn  <= btn_down_in;
      r_prev_clr <= btn_clr_in;
      if (w_guard) begin
        r_pend   <= w_ev;
        r_pend_d <= w_ev_d;
      end else begin
        r_pend   <= EV_NONE;
      end
      r_syn_clr  <= w_syn_clr_nx;
      r_load     <= w_load_nx;
      r_en       <= w_en_nx;
      r_up       <= w_up_nx;
      r_d        <= w_d_nx;
    end
  end

  assign syn_clr_o = r_syn_clr;
  assign load_o    = r_load;
  assign en_o      = r_en;
  assign up_o      = r_up;
  assign d_o       = r_d;

endmodule

// File: tb/tb_contador_cmd_gen.sv
// Bench for contador_cmd_gen: directed vector table, hold/guard/reset sequences and a
// randomized run against an event-level reference model (both AUTOREPEAT_EN builds).
module tb_contador_cmd_gen;
  localparam int N = 6, LIMIT = 59, DLY = 8, PER = 4;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int K_NONE = 0, K_DN = 1, K_UP = 2, K_LD = 3, K_CLR = 4;

  logic         clk = 1'b0, rst = 1'b1;
  logic         up = 1'b0, dn = 1'b0, clr = 1'b0, pl = 1'b0;
  logic [N-1:0] preset = '0, q_force = '0, ctr_q = '0, q_in;
  logic         use_ctr = 1'b0;
  logic         syn_clr, load, en, up_o, rep;
  logic [N-1:0] d;
  int           n_chk = 0, n_pass = 0;

  assign q_in = use_ctr ? ctr_q : q_force;

  always #5 clk = ~clk;

  contador_cmd_gen dut (
    .clock_clk_in(clk), .reset_rst_in(rst),
    .btn_up_in(up), .btn_down_in(dn), .btn_clr_in(clr),
    .preset_load_in(pl), .preset_in(preset), .q_in(q_in),
    .syn_clr_o(syn_clr), .load_o(load), .en_o(en), .up_o(up_o),
    .d_o(d), .repeat_o(rep)
  );

  // Universal counter driven by the DUT commands, or loaded from q_force when detached.
  always @(posedge clk) begin
    if (!use_ctr)     ctr_q <= q_force;
    else if (syn_clr) ctr_q <= '0;
    else if (load)    ctr_q <= d;
    else if (en)      ctr_q <= up_o ? ctr_q + 6'd1 : ctr_q - 6'd1;
  end

  typedef struct {
    logic       u, dn, c, p;
    logic [5:0] pre, q;
    logic [10:0] exp;
  } vec_t;

  function automatic logic [10:0] ex(input logic c, l, e, u, r, input logic [5:0] dd);
    return {c, l, e, u, r, dd};
  endfunction

  function automatic vec_t mkv(input logic u, dn_, c, p, input logic [5:0] pre, q,
                               input logic [10:0] exp);
    vec_t v;
    v.u = u; v.dn = dn_; v.c = c; v.p = p; v.pre = pre; v.q = q; v.exp = exp;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {syn_clr, load, en, up_o, rep, d};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b  {clr,load,en,up,rep,d}", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: previous button samples, held event, last-cycle strobe, hold age.
  logic m_pu, m_pd, m_pc, m_last, m_act, m_dir;
  int   m_pk, m_age;
  logic [5:0] m_pdat;

  task automatic model_init();
    m_pu = 1; m_pd = 1; m_pc = 1; m_last = 0; m_act = 0; m_dir = 0;
    m_pk = K_NONE; m_age = 0; m_pdat = '0;
  endtask

  task automatic model_step(input logic u, dn_, c, p, input logic [5:0] pre, q,
                            output logic [10:0] exp);
    logic pu, pd, pc, both, guard, held, tick_ok, fresh;
    logic oc, ol, oe, ou;
    logic [5:0] od, nd, ed;
    int nk, ek, ik, age;
    pu = u & ~m_pu; pd = dn_ & ~m_pd; pc = c & ~m_pc; both = u & dn_;
    nk = K_NONE; nd = '0;
    if (pc) nk = K_CLR;
    else if (p) begin nk = K_LD; nd = (pre > LIMIT) ? 6'(LIMIT) : pre; end
    else if (!both && pu) nk = K_UP;
    else if (!both && pd) nk = K_DN;
    ek = m_pk; ed = m_pdat;
    if (nk > m_pk) begin ek = nk; ed = nd; end
    guard = m_last;
    held  = m_dir ? u : dn_;
    age   = m_age + 1;
    tick_ok = AR && m_act && held && !both && !pc &&
              (age == DLY || (age > DLY && (age - DLY) % PER == 0));
    ik = K_NONE;
    if (!guard) ik = (ek != K_NONE) ? ek : (tick_ok ? (m_dir ? K_UP : K_DN) : K_NONE);
    oc = 0; ol = 0; oe = 0; ou = 0; od = '0;
    case (ik)
      K_CLR: oc = 1;
      K_LD:  begin ol = 1; od = ed; end
      K_UP:  if (q >= LIMIT) ol = 1; else begin oe = 1; ou = 1; end
      K_DN:  if (q == 0 || q > LIMIT) begin ol = 1; od = 6'(LIMIT); end else oe = 1;
      default: ;
    endcase
    fresh = !guard && (ek == K_UP || ek == K_DN);
    if (AR) begin
      if (both || pc) m_act = 0;
      else if (fresh) begin m_act = 1; m_dir = (ek == K_UP); m_age = 0; end
      else if (m_act) begin
        if (!held) m_act = 0;
        else m_age = age;
      end
    end
    m_pk   = guard ? ek : K_NONE;
    m_pdat = guard ? ed : '0;
    m_last = oc | ol | oe;
    m_pu = u; m_pd = dn_; m_pc = c;
    exp = ex(oc, ol, oe, ou, m_act && m_age >= DLY, od);
  endtask

  vec_t tbl[$];

  initial begin
    logic [10:0] e0, exp;
    logic [5:0]  q_now;
    e0 = '0;
    // Directed vectors, one per clock edge.
    tbl.push_back(mkv(0,0,0,0, 0,10, e0));
    tbl.push_back(mkv(1,0,0,0, 0,10, ex(0,0,1,1,0,0)));
    tbl.push_back(mkv(0,0,0,0, 0,11, e0));
    tbl.push_back(mkv(0,0,0,0, 0,11, e0));
    tbl.push_back(mkv(1,0,0,0, 0,59, ex(0,1,0,0,0,0)));
    tbl.push_back(mkv(0,0,0,0, 0, 0, e0));
    tbl.push_back(mkv(0,1,0,0, 0, 0, ex(0,1,0,0,0,59)));
    tbl.push_back(mkv(0,0,0,0, 0,59, e0));
    tbl.push_back(mkv(0,0,0,1,63, 5, ex(0,1,0,0,0,59)));
    tbl.push_back(mkv(0,0,0,0, 0, 5, e0));
    tbl.push_back(mkv(0,0,0,1,20, 5, ex(0,1,0,0,0,20)));
    tbl.push_back(mkv(0,0,0,0, 0,20, e0));
    tbl.push_back(mkv(0,0,1,1, 7,20, ex(1,0,0,0,0,0)));
    tbl.push_back(mkv(0,0,0,0, 0, 0, e0));
    tbl.push_back(mkv(1,1,0,0, 0,10, e0));
    tbl.push_back(mkv(0,0,0,0, 0,10, e0));
    tbl.push_back(mkv(0,1,0,0, 0,62, ex(0,1,0,0,0,59)));
    tbl.push_back(mkv(0,0,0,0, 0,59, e0));
    tbl.push_back(mkv(1,0,0,0, 0,62, ex(0,1,0,0,0,0)));
    tbl.push_back(mkv(0,0,0,0, 0, 0, e0));
    tbl.push_back(mkv(0,1,0,0, 0,10, ex(0,0,1,0,0,0)));
    tbl.push_back(mkv(0,0,0,1,30, 9, e0));
    tbl.push_back(mkv(0,0,0,0, 0, 9, ex(0,1,0,0,0,30)));
    tbl.push_back(mkv(0,0,0,0, 0,30, e0));
    tbl.push_back(mkv(1,0,0,0, 0,10, ex(0,0,1,1,0,0)));
    tbl.push_back(mkv(0,0,1,1, 3,11, e0));
    tbl.push_back(mkv(0,0,1,0, 0,11, ex(1,0,0,0,0,0)));
    tbl.push_back(mkv(0,0,0,0, 0, 0, e0));

    // Reset values.
    repeat (2) tick();
    check("reset_state", outs(), e0);
    #2 rst = 1'b0;

    foreach (tbl[i]) begin
      up = tbl[i].u; dn = tbl[i].dn; clr = tbl[i].c; pl = tbl[i].p;
      preset = tbl[i].pre; q_force = tbl[i].q;
      tick();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    up = 0; dn = 0; clr = 0; pl = 0;

    // Hold up for 30 cycles with the counter attached, starting near the wrap point.
    q_force = 6'd55;
    tick();
    use_ctr = 1'b1;
    for (int off = 0; off < 30; off++) begin
      bit exp_s;
      up = 1'b1;
      exp_s = (off == 0) || (AR && off >= DLY && (off - DLY) % PER == 0);
      tick();
      check($sformatf("hold_strobe%0d", off), 11'(en | load), 11'(exp_s));
      check($sformatf("hold_rep%0d", off), 11'(rep), 11'(AR && off >= DLY));
    end
    up = 1'b0;
    tick();
    check("hold_release", outs(), e0);
    check("hold_count", 11'(ctr_q), AR ? 11'd2 : 11'd56);

    // Direction change in the guard cycle: the pended down step sees the wrapped value.
    use_ctr = 1'b0; q_force = 6'd59;
    tick();
    use_ctr = 1'b1;
    up = 1'b1;
    tick();
    check("dirchg_up_wrap", outs(), ex(0,1,0,0,0,0));
    up = 1'b0; dn = 1'b1;
    tick();
    check("dirchg_guard", outs(), e0);
    tick();
    check("dirchg_pended", outs(), ex(0,1,0,0,0,59));
    dn = 1'b0;
    tick();
    check("dirchg_after", outs(), e0);

    // Reset asserted mid-hold; a button still held afterwards must be re-pressed.
    use_ctr = 1'b0; q_force = 6'd10;
    up = 1'b1;
    repeat (12) tick();
    #2 rst = 1'b1;
    #1 check("rst_async", outs(), e0);
    repeat (2) tick();
    check("rst_held", outs(), e0);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("held_after_rst%0d", i), outs(), e0);
    end
    up = 1'b0;
    tick();
    check("rst_release", outs(), e0);
    up = 1'b1;
    tick();
    check("rst_repress", outs(), ex(0,0,1,1,0,0));
    up = 1'b0;
    tick();
    check("rst_repress_end", outs(), e0);

    // Randomized run against the reference model.
    dn = 0; clr = 0; pl = 0;
    #2 rst = 1'b1;
    tick();
    #2 rst = 1'b0;
    model_init();
    for (int i = 0; i < 2000; i++) begin
      up      = up  ^ ($urandom_range(0, 11) == 0);
      dn      = dn  ^ ($urandom_range(0, 11) == 0);
      clr     = clr ^ ($urandom_range(0, 19) == 0);
      pl      = ($urandom_range(0, 11) == 0);
      preset  = 6'($urandom_range(0, 63));
      use_ctr = ($urandom_range(0, 15) != 0);
      q_force = 6'($urandom_range(0, 63));
      q_now   = use_ctr ? ctr_q : q_force;
      model_step(up, dn, clr, pl, preset, q_now, exp);
      tick();
      check($sformatf("rand%0d", i), outs(), exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
